// File: rtl/mux4way_arbiter_pkg.sv
// Shared Hack memory-port definitions: default widths, output-slot state and requester ids.
package hack_pkg;
    localparam int HACK_DATA_W = 16;
    localparam int HACK_ADDR_W = 15;
    localparam int NUM_REQ     = 4;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;
    typedef logic [1:0] src_id_t;

    function automatic logic [NUM_REQ-1:0] src_onehot(input src_id_t id);
        return 4'b0001 << id;
    endfunction
endpackage

// File: rtl/mux4way_arbiter_rr_pick4.sv
// Round-robin pick of one of four requests, scanning upward from ptr+1 modulo 4.
module rr_pick4
    import hack_pkg::*;
(
    input  logic [3:0] req,
    input  src_id_t    ptr,
    output logic [3:0] grant,
    output src_id_t    idx
);
    src_id_t cand;
    logic    found;

    always_comb begin
        grant = 4'b0000;
        idx   = ptr;
        cand  = ptr;
        found = 1'b0;
        // k = 4 wraps back to ptr itself, so the last winner is checked last.
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + src_id_t'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (found)
            grant = src_onehot(idx);
    end
endmodule

// File: rtl/mux4way_arbiter.sv
// Four-master round-robin arbiter feeding one registered output slot on the shared memory port.
module mux4way_arbiter
    import hack_pkg::*;
#(
    parameter int DATA_W = HACK_DATA_W,
    parameter int ADDR_W = HACK_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req_valid,
    output logic [3:0]          req_ready,
    input  logic [3:0]          req_we,
    input  logic [3:0]          req_lock,
    input  logic [4*ADDR_W-1:0] req_addr,
    input  logic [4*DATA_W-1:0] req_wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [DATA_W-1:0]   out_wdata,
    output logic                out_we,
    output src_id_t             out_src
);
    slot_state_t state_q, state_d;
    src_id_t     ptr_q, win_idx;
    logic        locked_q;
    logic [3:0]  eligible, grant;
    logic        slot_free, accept;

    // While locked, ptr_q is the lock owner: it was the last requester accepted.
    assign eligible = locked_q ? (req_valid & src_onehot(ptr_q)) : req_valid;

    rr_pick4 u_pick (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx)
    );

    // A draining slot can take a new entry in the same cycle.
    assign slot_free = (state_q == EMPTY) || out_ready;
    assign req_ready = (rst_n && slot_free) ? grant : 4'b0000;
    assign accept    = |req_ready;
    assign out_valid = (state_q == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr  <= '0;
            out_wdata <= '0;
            out_we    <= 1'b0;
            out_src   <= '0;
        end else if (accept) begin
            out_addr  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            out_wdata <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
            out_we    <= req_we[win_idx];
            out_src   <= win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= 2'd3;
            locked_q <= 1'b0;
        end else if (accept) begin
            ptr_q    <= win_idx;
            locked_q <= req_lock[win_idx];
        end else if (locked_q && !req_valid[ptr_q] && !req_lock[ptr_q]) begin
            // Owner released the lock while idle.
            locked_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux4way_arbiter.sv
// Directed bench for mux4way_arbiter: reset, fairness, stall, lock, async reset and sparse traffic.
module tb_mux4way_arbiter;
    localparam int AW = 15;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_valid, req_ready, req_we, req_lock;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_wdata;
    logic            out_valid, out_ready, out_we;
    logic [AW-1:0]   out_addr;
    logic [DW-1:0]   out_wdata;
    logic [1:0]      out_src;

    int n_cmp = 0;
    int n_bad = 0;

    mux4way_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_wdata (out_wdata),
        .out_we    (out_we),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    // Requester protocol: a pending request must hold valid and payload until accepted.
    logic            prev_rst = 1'b0;
    logic [3:0]      prev_pend = 4'b0;
    logic [4*AW-1:0] prev_addr;
    logic [4*DW-1:0] prev_wdata;
    logic [3:0]      prev_we;
    always @(posedge clk) begin
        if (rst_n && prev_rst)
            for (int i = 0; i < 4; i++)
                if (prev_pend[i])
                    assert (req_valid[i] && req_addr[i*AW +: AW] == prev_addr[i*AW +: AW]
                            && req_wdata[i*DW +: DW] == prev_wdata[i*DW +: DW] && req_we[i] == prev_we[i])
                    else $error("requester %0d dropped or changed its request before accept", i);
        prev_rst   <= rst_n;
        prev_pend  <= req_valid & ~req_ready;
        prev_addr  <= req_addr;
        prev_wdata <= req_wdata;
        prev_we    <= req_we;
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_we[i]             = we;
    endtask

    task automatic set_std_payloads();
        for (int i = 0; i < 4; i++)
            set_req(i, AW'(32'h100 + i), DW'(32'hA000 + i), i[0]);
    endtask

    // Called at a negedge; returns at the negedge after reset is released.
    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 4'b0;
        req_lock = 4'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        req_lock = 4'b0;
        out_ready = 1'b1;
        req_addr = '0;
        req_wdata = '0;
        req_we = '0;
        set_std_payloads();
        @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        n_cmp++; if (out_addr !== '0) begin n_bad++; $display("FAIL reset_out_addr got=%0h exp=0", out_addr); end
        n_cmp++; if (out_wdata !== '0) begin n_bad++; $display("FAIL reset_out_wdata got=%0h exp=0", out_wdata); end
        n_cmp++; if (out_we !== 1'b0) begin n_bad++; $display("FAIL reset_out_we got=%0h exp=0", out_we); end
        n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL reset_out_src got=%0h exp=0", out_src); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_addr !== 15'h100)
            begin n_bad++; $display("FAIL reset_first_out got=v%0h s%0h a%0h exp=v1 s0 a100", out_valid, out_src, out_addr); end
        // ptr now 0, so requester 1 is next.
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL reset_ptr0_grant got=%b exp=0010", req_ready); end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [1:0] es;
        logic [3:0] er;
        for (int k = 1; k <= 8; k++) begin
            es = 2'(k % 4);
            er = 4'b0001 << ((k + 1) % 4);
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_src !== es || out_addr !== AW'(32'h100 + k % 4) || out_we !== es[0])
                begin n_bad++; $display("FAIL fair_out[%0d] got=v%0h s%0h a%0h w%0h exp=v1 s%0h a%0h w%0h",
                      k, out_valid, out_src, out_addr, out_we, es, 32'h100 + k % 4, es[0]); end
            n_cmp++; if (req_ready !== er) begin n_bad++; $display("FAIL fair_ready[%0d] got=%b exp=%b", k, req_ready, er); end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        set_req(2, 15'h1234, 16'hBEEF, 1'b1);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL stall_grant got=%b exp=0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0001;
        set_req(0, 15'h0042, 16'h1111, 1'b0);
        for (int s = 0; s < 3; s++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_addr !== 15'h1234 || out_wdata !== 16'hBEEF || out_we !== 1'b1 || out_src !== 2'd2)
                begin n_bad++; $display("FAIL stall_hold[%0d] got=v%0h a%0h d%0h w%0h s%0h exp=v1 a1234 dbeef w1 s2",
                      s, out_valid, out_addr, out_wdata, out_we, out_src); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready[%0d] got=%b exp=0000", s, req_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL stall_drain_accept got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_addr !== 15'h0042 || out_wdata !== 16'h1111 || out_we !== 1'b0)
            begin n_bad++; $display("FAIL stall_replace got=v%0h s%0h a%0h d%0h w%0h exp=v1 s0 a42 d1111 w0",
                  out_valid, out_src, out_addr, out_wdata, out_we); end
        @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_empty got=%0h exp=0", out_valid); end
        @(negedge clk);
    endtask

    task automatic test_lock();
        // Per cycle: requester 1 valid/lock/addr, requester 3 valid, expected ready and output slot.
        logic       v1 [7] = '{1, 1, 0, 1, 1, 0, 0};
        logic       l1 [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [7:0] a1 [7] = '{8'h10, 8'h11, 8'h11, 8'h12, 8'h13, 8'h13, 8'h13};
        logic       v3 [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [3:0] er [7] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b0000};
        logic       ev [7] = '{0, 1, 1, 0, 1, 1, 1};
        logic [1:0] esr[7] = '{0, 1, 1, 0, 1, 1, 3};
        logic [AW-1:0] ea [7] = '{15'h0, 15'h110, 15'h111, 15'h0, 15'h112, 15'h113, 15'h333};
        out_ready = 1'b1;
        set_req(3, 15'h0333, 16'h3333, 1'b0);
        for (int c = 0; c < 7; c++) begin
            req_valid = {v3[c], 1'b0, v1[c], 1'b0};
            req_lock  = {2'b00, l1[c], 1'b0};
            set_req(1, {7'h01, a1[c]}, 16'h1000, 1'b1);
            #1;
            n_cmp++; if (req_ready !== er[c]) begin n_bad++; $display("FAIL lock_ready[%0d] got=%b exp=%b", c, req_ready, er[c]); end
            n_cmp++; if (out_valid !== ev[c] || (ev[c] && (out_src !== esr[c] || out_addr !== ea[c])))
                begin n_bad++; $display("FAIL lock_out[%0d] got=v%0h s%0h a%0h exp=v%0h s%0h a%0h",
                      c, out_valid, out_src, out_addr, ev[c], esr[c], ea[c]); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_req(2, 15'h0222, 16'h2222, 1'b1);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL arst_grant got=%b exp=0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd2) begin n_bad++; $display("FAIL arst_full got=v%0h s%0h exp=v1 s2", out_valid, out_src); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_src !== 2'd0 || out_addr !== '0 || out_wdata !== '0 || out_we !== 1'b0)
            begin n_bad++; $display("FAIL arst_clear got=v%0h s%0h a%0h d%0h w%0h exp=all 0",
                  out_valid, out_src, out_addr, out_wdata, out_we); end
        set_std_payloads();
        req_valid = 4'b1111;
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin n_bad++; $display("FAIL arst_restart got=v%0h s%0h exp=v1 s0", out_valid, out_src); end
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL arst_next_ready got=%b exp=0010", req_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (out_src !== 2'd1) begin n_bad++; $display("FAIL arst_second got=%0h exp=1", out_src); end
        do_reset();
    endtask

    task automatic test_sparse();
        out_ready = 1'b1;
        set_req(3, 15'h0303, 16'h0033, 1'b1);
        req_valid = 4'b1000;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL sparse_r3 got=%b exp=1000", req_ready); end
        @(negedge clk);
        set_req(0, 15'h0300, 16'h0030, 1'b0);
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (out_src !== 2'd3 || out_addr !== 15'h0303 || out_wdata !== 16'h0033) begin n_bad++; $display("FAIL sparse_out3 got=s%0h a%0h d%0h exp=s3 a303 d33", out_src, out_addr, out_wdata); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL sparse_r0_wrap got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        n_cmp++; if (out_src !== 2'd0 || out_addr !== 15'h0300) begin n_bad++; $display("FAIL sparse_out0 got=s%0h a%0h exp=s0 a300", out_src, out_addr); end
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL sparse_r3_again got=%b exp=1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd3) begin n_bad++; $display("FAIL sparse_out3b got=v%0h s%0h exp=v1 s3", out_valid, out_src); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fairness();
        do_reset();
        test_stall();
        do_reset();
        test_lock();
        do_reset();
        test_async_reset();
        test_sparse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
